// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: OAM DMA engine that shares the system bus with the CPU and copies DMA_LEN bytes into OAM
module oam_dma_arbiter #(
    parameter int          DMA_LEN = 160,
    parameter logic [15:0] DMA_REG = 16'hFF46
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic [6:0]  hram_addr,
    output logic        hram_enable,
    output logic        hram_write,
    output logic [7:0]  hram_data_out,
    input  logic [7:0]  hram_data_in,
    output logic [7:0]  oam_addr,
    output logic        oam_write,
    output logic [7:0]  oam_data,
    output logic        dma_active
);
    typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;
    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
    state_t state_q, state_d;
    logic [7:0] src_q, src_d, idx_q, idx_d;
    logic boundary, reg_hit, hram_hit, reg_write, active;
    // Address decode and M-cycle boundary detection
    always_comb begin
        boundary  = t_cycle == 2'd3;
        reg_hit   = cpu_addr == DMA_REG;
        hram_hit  = cpu_addr >= 16'hFF80 && cpu_addr != 16'hFFFF;
        reg_write = cpu_enable && cpu_write && reg_hit;
        active    = state_q == ACTIVE;
    end
    // Next state: a register write restarts from anywhere; otherwise step the transfer once per M-cycle
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        if (boundary) begin
            if (reg_write) begin
                src_d   = cpu_data_out;
                state_d = START;
            end else if (state_q == START) begin
                state_d = ACTIVE;
                idx_d   = '0;
            end else if (active) begin
                idx_d   = idx_q + 8'd1;
                state_d = idx_q == LAST_IDX ? IDLE : ACTIVE;
            end
        end
    end
    // State, source and index registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
        end
    end
    // Bus ownership, HRAM routing, OAM write strobe and CPU read-data steering
    always_comb begin
        bus_addr      = active ? {src_q, idx_q} : cpu_addr;
        bus_enable    = active || (cpu_enable && !hram_hit && !reg_hit);
        bus_write     = !active && cpu_enable && cpu_write && !hram_hit && !reg_hit;
        bus_data_out  = active ? 8'h00 : cpu_data_out;
        hram_addr     = cpu_addr[6:0];
        hram_enable   = cpu_enable && hram_hit && !reset;
        hram_write    = hram_enable && cpu_write;
        hram_data_out = cpu_data_out;
        oam_write     = active && boundary;
        oam_addr      = idx_q;
        oam_data      = bus_data_in;
        dma_active    = active;
        cpu_data_in   = reg_hit ? src_q : hram_hit ? hram_data_in : active ? 8'hFF : bus_data_in;
    end
endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb_oam_dma_arbiter: directed and randomized checks of the OAM DMA arbiter against an M-cycle timeline model
module tb_oam_dma_arbiter;
    localparam int LEN = 160;
    logic clk = 1'b0, reset = 1'b1;
    logic [1:0] t_cycle = 2'd0;
    logic [15:0] cpu_addr = '0;
    logic cpu_enable = 1'b0, cpu_write = 1'b0;
    logic [7:0] cpu_data_out = '0, cpu_data_in;
    logic [15:0] bus_addr;
    logic bus_enable, bus_write;
    logic [7:0] bus_data_out, bus_data_in;
    logic [6:0] hram_addr;
    logic hram_enable, hram_write;
    logic [7:0] hram_data_out, hram_data_in;
    logic [7:0] oam_addr, oam_data;
    logic oam_write, dma_active;
    int tests = 0, fails = 0;
    int mcyc = 0;
    int trig_m = -1000;
    logic [7:0] m_src = 8'h00;

    oam_dma_arbiter dut (
        .clk(clk), .reset(reset), .t_cycle(t_cycle),
        .cpu_addr(cpu_addr), .cpu_enable(cpu_enable), .cpu_write(cpu_write),
        .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
        .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
        .hram_addr(hram_addr), .hram_enable(hram_enable), .hram_write(hram_write),
        .hram_data_out(hram_data_out), .hram_data_in(hram_data_in),
        .oam_addr(oam_addr), .oam_write(oam_write), .oam_data(oam_data),
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    // Memory models: bus returns addr[7:0]^5A, HRAM returns {0,addr}^C3
    assign bus_data_in  = bus_addr[7:0] ^ 8'h5A;
    assign hram_data_in = {1'b0, hram_addr} ^ 8'hC3;

    task automatic set_cpu(input logic en, input logic wr, input logic [15:0] a, input logic [7:0] d);
        cpu_enable = en; cpu_write = wr; cpu_addr = a; cpu_data_out = d;
    endtask

    // One T-cycle; a DMA register write seen at an M-cycle boundary becomes the new trigger point
    task automatic adv();
        bit w;
        logic [7:0] wd;
        w = !reset && t_cycle == 2'd3 && cpu_enable && cpu_write && cpu_addr == 16'hFF46;
        wd = cpu_data_out;
        @(posedge clk);
        #1;
        if (w) begin trig_m = mcyc; m_src = wd; end
        if (t_cycle == 2'd3) mcyc++;
        t_cycle = t_cycle + 2'd1;
    endtask

    task automatic to_mstart();
        while (t_cycle != 2'd0) adv();
    endtask

    task automatic run_m(input int n);
        repeat (n * 4) adv();
    endtask

    task automatic model_reset();
        trig_m = -1000; m_src = 8'h00;
    endtask

    task automatic test_reset();
        set_cpu(1, 0, 16'hFF46, 8'h00); #1;
        tests++; if (dma_active !== 1'b0) begin fails++; $display("FAIL rst_active got %b exp 0", dma_active); end
        tests++; if (cpu_data_in !== 8'h00) begin fails++; $display("FAIL rst_src got %h exp 00", cpu_data_in); end
        tests++; if (bus_enable !== 1'b0) begin fails++; $display("FAIL rst_reg_busen got %b exp 0", bus_enable); end
        set_cpu(1, 1, 16'h1234, 8'h77); #1;
        tests++; if (bus_enable !== 1'b1 || bus_addr !== 16'h1234 || bus_write !== 1'b1 || bus_data_out !== 8'h77)
            begin fails++; $display("FAIL rst_pass got en=%b a=%h w=%b d=%h exp 1 1234 1 77", bus_enable, bus_addr, bus_write, bus_data_out); end
        tests++; if (oam_write !== 1'b0) begin fails++; $display("FAIL rst_oamw got %b exp 0", oam_write); end
        set_cpu(1, 1, 16'hFF90, 8'h11); #1;
        tests++; if (hram_enable !== 1'b0) begin fails++; $display("FAIL rst_hram_en got %b exp 0", hram_enable); end
        repeat (3) adv();
        reset = 1'b0;
        set_cpu(0, 0, 16'h0000, 8'h00);
        to_mstart();
        repeat (16) begin
            #1; tests++; if (dma_active !== 1'b0) begin fails++; $display("FAIL rst_release got %b exp 0", dma_active); end
            adv();
        end
    endtask

    task automatic test_full_transfer();
        int n0;
        to_mstart();
        set_cpu(1, 1, 16'hFF46, 8'hC1);
        run_m(1);
        set_cpu(0, 0, 16'h0000, 8'h00);
        n0 = mcyc;
        repeat (4) begin
            #1; tests++; if (dma_active !== 1'b0 || oam_write !== 1'b0 || bus_enable !== 1'b0)
                begin fails++; $display("FAIL full_start got act=%b ow=%b be=%b exp 0 0 0", dma_active, oam_write, bus_enable); end
            adv();
        end
        for (int k = 0; k < LEN; k++) begin
            for (int t = 0; t < 4; t++) begin
                #1;
                tests++; if (dma_active !== 1'b1 || bus_enable !== 1'b1 || bus_write !== 1'b0 || bus_addr !== {8'hC1, 8'(k)})
                    begin fails++; $display("FAIL full_bus k=%0d got act=%b en=%b w=%b a=%h exp 1 1 0 %h", k, dma_active, bus_enable, bus_write, bus_addr, {8'hC1, 8'(k)}); end
                tests++; if (oam_write !== (t == 3)) begin fails++; $display("FAIL full_oamw k=%0d t=%0d got %b exp %b", k, t, oam_write, t == 3); end
                if (t == 3) begin
                    tests++; if (oam_addr !== 8'(k) || oam_data !== (8'(k) ^ 8'h5A))
                        begin fails++; $display("FAIL full_oam k=%0d got a=%h d=%h exp %h %h", k, oam_addr, oam_data, 8'(k), 8'(k) ^ 8'h5A); end
                end
                adv();
            end
        end
        #1;
        tests++; if (mcyc !== n0 + LEN + 1 || dma_active !== 1'b0)
            begin fails++; $display("FAIL full_end got m=%0d act=%b exp %0d 0", mcyc, dma_active, n0 + LEN + 1); end
    endtask

    task automatic test_blocked_restart();
        int cnt, guard;
        to_mstart();
        set_cpu(1, 1, 16'hFF46, 8'hC1);
        run_m(1);
        set_cpu(0, 0, 16'h0000, 8'h00);
        run_m(1);
        set_cpu(1, 0, 16'h8000, 8'h00); #1;
        tests++; if (cpu_data_in !== 8'hFF || bus_addr !== 16'hC100)
            begin fails++; $display("FAIL blk_read got d=%h a=%h exp FF C100", cpu_data_in, bus_addr); end
        run_m(1);
        set_cpu(1, 1, 16'hC000, 8'h55); #1;
        tests++; if (bus_write !== 1'b0 || bus_data_out !== 8'h00 || bus_addr !== 16'hC101)
            begin fails++; $display("FAIL blk_write got w=%b d=%h a=%h exp 0 00 C101", bus_write, bus_data_out, bus_addr); end
        run_m(1);
        set_cpu(1, 1, 16'hFF90, 8'hAA); #1;
        tests++; if (hram_enable !== 1'b1 || hram_write !== 1'b1 || hram_addr !== 7'h10 || hram_data_out !== 8'hAA)
            begin fails++; $display("FAIL blk_hram got en=%b w=%b a=%h d=%h exp 1 1 10 AA", hram_enable, hram_write, hram_addr, hram_data_out); end
        run_m(1);
        set_cpu(0, 0, 16'h0000, 8'h00);
        run_m(8'h40 - 3);
        #1;
        tests++; if (bus_addr !== 16'hC140) begin fails++; $display("FAIL rst_at40 got %h exp C140", bus_addr); end
        set_cpu(1, 1, 16'hFF46, 8'hD0);
        repeat (3) adv();
        #1;
        tests++; if (oam_write !== 1'b1 || oam_addr !== 8'h40 || oam_data !== 8'h1A)
            begin fails++; $display("FAIL restart_last got w=%b a=%h d=%h exp 1 40 1A", oam_write, oam_addr, oam_data); end
        adv();
        set_cpu(1, 0, 16'h1234, 8'h00); #1;
        tests++; if (dma_active !== 1'b0 || bus_addr !== 16'h1234 || bus_enable !== 1'b1 || cpu_data_in !== 8'h6E)
            begin fails++; $display("FAIL restart_start got act=%b a=%h en=%b d=%h exp 0 1234 1 6E", dma_active, bus_addr, bus_enable, cpu_data_in); end
        run_m(1);
        set_cpu(0, 0, 16'h0000, 8'h00);
        cnt = 0; guard = 0;
        while (cnt < LEN && guard < 4 * (LEN + 10)) begin
            #1;
            if (oam_write === 1'b1) begin
                tests++; if (oam_addr !== 8'(cnt) || bus_addr !== {8'hD0, 8'(cnt)})
                    begin fails++; $display("FAIL restart_byte n=%0d got a=%h b=%h exp %h %h", cnt, oam_addr, bus_addr, 8'(cnt), {8'hD0, 8'(cnt)}); end
                cnt++;
            end
            adv();
            guard++;
        end
        #1;
        tests++; if (cnt !== LEN || guard !== 4 * LEN) begin fails++; $display("FAIL restart_count got n=%0d t=%0d exp %0d %0d", cnt, guard, LEN, 4 * LEN); end
        tests++; if (dma_active !== 1'b0) begin fails++; $display("FAIL restart_end got %b exp 0", dma_active); end
    endtask

    task automatic test_reset_mid();
        to_mstart();
        set_cpu(1, 1, 16'hFF46, 8'hC1);
        run_m(1);
        set_cpu(0, 0, 16'h0000, 8'h00);
        run_m(1 + 8'h20);
        repeat (3) adv();
        #1;
        tests++; if (oam_write !== 1'b1 || oam_addr !== 8'h20) begin fails++; $display("FAIL mid_pre got w=%b a=%h exp 1 20", oam_write, oam_addr); end
        reset = 1'b1;
        model_reset();
        #1;
        tests++; if (dma_active !== 1'b0 || oam_write !== 1'b0 || bus_enable !== 1'b0)
            begin fails++; $display("FAIL mid_reset got act=%b ow=%b be=%b exp 0 0 0", dma_active, oam_write, bus_enable); end
        repeat (4) adv();
        reset = 1'b0;
        repeat (12) begin
            #1; tests++; if (dma_active !== 1'b0 || oam_write !== 1'b0)
                begin fails++; $display("FAIL mid_after got act=%b ow=%b exp 0 0", dma_active, oam_write); end
            adv();
        end
        set_cpu(1, 0, 16'hFF46, 8'h00); #1;
        tests++; if (cpu_data_in !== 8'h00 || bus_enable !== 1'b0)
            begin fails++; $display("FAIL mid_src got d=%h en=%b exp 00 0", cpu_data_in, bus_enable); end
        set_cpu(0, 0, 16'h0000, 8'h00);
    endtask

    task automatic test_reg_read();
        to_mstart();
        set_cpu(1, 1, 16'hFF46, 8'h80);
        run_m(1);
        set_cpu(1, 0, 16'hFF46, 8'h00); #1;
        tests++; if (dma_active !== 1'b0 || cpu_data_in !== 8'h80 || bus_enable !== 1'b0)
            begin fails++; $display("FAIL reg_start got act=%b d=%h en=%b exp 0 80 0", dma_active, cpu_data_in, bus_enable); end
        run_m(1); #1;
        tests++; if (dma_active !== 1'b1 || cpu_data_in !== 8'h80 || bus_addr !== 16'h8000)
            begin fails++; $display("FAIL reg_active got act=%b d=%h a=%h exp 1 80 8000", dma_active, cpu_data_in, bus_addr); end
        set_cpu(0, 0, 16'h0000, 8'h00);
        run_m(LEN); #1;
        tests++; if (dma_active !== 1'b0) begin fails++; $display("FAIL reg_done got %b exp 0", dma_active); end
        set_cpu(1, 0, 16'hFF46, 8'h00); #1;
        tests++; if (cpu_data_in !== 8'h80 || bus_enable !== 1'b0)
            begin fails++; $display("FAIL reg_idle got d=%h en=%b exp 80 0", cpu_data_in, bus_enable); end
        set_cpu(0, 0, 16'h0000, 8'h00);
    endtask

    // Random CPU traffic with occasional DMA triggers, each T-cycle checked against the M-cycle timeline
    task automatic test_random();
        int d;
        logic act, hr, rg, e_ben, e_bwr, e_oam, e_hen;
        logic [7:0] ix, e_cdi;
        logic [15:0] a, e_badr;
        to_mstart();
        for (int i = 0; i < 6000; i++) begin
            if (t_cycle == 2'd0) begin
                if ($urandom_range(0, 199) == 0)
                    set_cpu(1, 1, 16'hFF46, $urandom_range(0, 1) != 0 ? 8'($urandom_range(224, 255)) : 8'($urandom));
                else begin
                    case ($urandom_range(0, 5))
                        0: a = 16'hFF46;
                        1: a = 16'hFF80 + 16'($urandom_range(0, 126));
                        2: a = 16'hFF7F;
                        3: a = 16'hFFFF;
                        default: a = 16'($urandom);
                    endcase
                    set_cpu($urandom_range(0, 3) != 0, a != 16'hFF46 && $urandom_range(0, 1) != 0, a, 8'($urandom));
                end
            end
            #1;
            a = cpu_addr;
            d = mcyc - trig_m;
            act = d >= 2 && d <= LEN + 1;
            ix = 8'(d - 2);
            hr = a >= 16'hFF80 && a <= 16'hFFFE;
            rg = a == 16'hFF46;
            e_ben = act || (cpu_enable && !hr && !rg);
            e_badr = act ? {m_src, ix} : a;
            e_bwr = !act && cpu_enable && cpu_write && !hr && !rg;
            e_cdi = rg ? m_src : hr ? ({1'b0, a[6:0]} ^ 8'hC3) : act ? 8'hFF : (a[7:0] ^ 8'h5A);
            e_oam = act && t_cycle == 2'd3;
            e_hen = cpu_enable && hr;
            tests++; if (dma_active !== act) begin fails++; $display("FAIL rnd_active m=%0d got %b exp %b", mcyc, dma_active, act); end
            tests++; if (bus_enable !== e_ben || bus_addr !== e_badr || bus_write !== e_bwr)
                begin fails++; $display("FAIL rnd_bus m=%0d got en=%b a=%h w=%b exp %b %h %b", mcyc, bus_enable, bus_addr, bus_write, e_ben, e_badr, e_bwr); end
            tests++; if (cpu_data_in !== e_cdi) begin fails++; $display("FAIL rnd_cpu_rd m=%0d a=%h got %h exp %h", mcyc, a, cpu_data_in, e_cdi); end
            tests++; if (hram_enable !== e_hen) begin fails++; $display("FAIL rnd_hram m=%0d got %b exp %b", mcyc, hram_enable, e_hen); end
            tests++; if (oam_write !== e_oam) begin fails++; $display("FAIL rnd_oamw m=%0d got %b exp %b", mcyc, oam_write, e_oam); end
            if (e_oam) begin
                tests++; if (oam_addr !== ix || oam_data !== (ix ^ 8'h5A))
                    begin fails++; $display("FAIL rnd_oam m=%0d got a=%h d=%h exp %h %h", mcyc, oam_addr, oam_data, ix, ix ^ 8'h5A); end
            end
            adv();
        end
        set_cpu(0, 0, 16'h0000, 8'h00);
    endtask

    initial begin
        test_reset();
        test_full_transfer();
        test_blocked_restart();
        test_reset_mid();
        test_reg_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got still running exp finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, meaning bytes copied per transfer (1..256).
REQ-002 SHALL have parameter DMA_REG, default 16'hFF46, meaning the CPU-visible DMA source register address.
REQ-003 clk  input  1  system clock (4 MHz T-cycle clock). One clock; reset is asynchronous and active-high.
REQ-004 reset  input  1  asynchronous reset, active high.
REQ-005 t_cycle  input  2  current T-cycle within the M-cycle (0..3), from the CPU.
REQ-006 cpu_addr/cpu_enable/cpu_write/cpu_data_out  input  16/1/1/8  CPU bus request.
REQ-007 cpu_data_in  output  8  read data returned to the CPU.
REQ-008 bus_addr/bus_enable/bus_write/bus_data_out  output  16/1/1/8  shared system bus request.
REQ-009 bus_data_in  input  8  shared system bus read data.
REQ-010 hram_addr/hram_enable/hram_write/hram_data_out  output  7/1/1/8  private high-RAM port; hram_data_in input 8.
REQ-011 oam_addr/oam_write/oam_data  output  8/1/8  OAM write port.
REQ-012 dma_active  output  1  high while state is ACTIVE.

Function
REQ-013 SHALL implement states IDLE, START, ACTIVE; an M-cycle boundary is the clk edge where t_cycle==3.
REQ-014 SHALL hold an 8-bit source register src and an 8-bit index idx.
REQ-015 CPU write to DMA_REG (cpu_enable&&cpu_write) SHALL latch cpu_data_out into src at the t_cycle==3 edge and enter START from any state, aborting any transfer in progress.
REQ-016 CPU read of DMA_REG SHALL return src on cpu_data_in; DMA_REG accesses SHALL never drive bus_enable.
REQ-017 START SHALL last exactly one M-cycle, set idx=0 on exit, then enter ACTIVE; during START the CPU owns the bus.
REQ-018 In ACTIVE: bus_addr={src,idx}, bus_enable=1, bus_write=0, bus_data_out=0 for all four T-cycles.
REQ-019 In ACTIVE at t_cycle==3: oam_write=1, oam_addr=idx, oam_data=bus_data_in (combinational); oam_write SHALL be 0 at all other times.
REQ-020 At each ACTIVE M-cycle boundary idx SHALL increment; after the transfer with idx==DMA_LEN-1 state SHALL return to IDLE.
REQ-021 A full transfer SHALL take 1 START + DMA_LEN ACTIVE M-cycles; no byte is skipped or duplicated.
REQ-022 CPU accesses to FF80-FFFE SHALL always route to the hram port (hram_addr=cpu_addr[6:0]) in every state, returning hram_data_in, and never drive bus_enable.
REQ-023 Outside ACTIVE, all other CPU accesses SHALL pass through to the bus unchanged and cpu_data_in=bus_data_in.
REQ-024 In ACTIVE, CPU accesses other than HRAM and DMA_REG SHALL be blocked: writes dropped, reads return 8'hFF.
REQ-025 src values >= 8'hE0 SHALL be used unmodified on bus_addr (no mirroring in this block).
REQ-026 DMA_REG write during ACTIVE SHALL take effect at that boundary: the byte of that M-cycle is still written to OAM, next M-cycle is START, bus returns to the CPU for that M-cycle.
REQ-027 dma_active SHALL be 0 in IDLE and START.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, src=0, idx=0, dma_active=0, oam_write=0, hram_enable=0; bus outputs then follow the CPU pass-through rule.
REQ-029 reset asserted mid-transfer SHALL abort it with no further oam_write; deassertion SHALL not start a transfer.

Verification
REQ-030 Write 8'hC1 to FF46 in M-cycle N -> START in N+1, ACTIVE N+2..N+161, bus_addr C100..C19F, oam_addr 00..9F, IDLE at N+162.
REQ-031 Bus returns data=addr[7:0]^8'h5A during DMA -> each oam_data equals that pattern at oam_write pulse.
REQ-032 CPU read 0x8000 and write 0xC000 during ACTIVE -> cpu_data_in=8'hFF, no CPU bus write; CPU write 0xFF90 -> hram_write=1, hram_addr=7'h10.
REQ-033 Write 8'hD0 to FF46 at idx=0x40 -> byte 0x40 still written, one START M-cycle, then restart from D000 with idx=0 for 160 bytes.
REQ-034 Assert reset at idx=0x20 -> immediately dma_active=0, oam_write=0; read FF46 after reset returns 8'h00.
REQ-035 Read FF46 after writing 8'h80 -> returns 8'h80 in any state, bus_enable=0 for that access.
